// File: rtl/mem_arbiter_pkg.sv
// Shared types and default constants for the single-port memory arbiter.
// The address width matches the word-address width of m_amemory.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W     = 11;
    localparam int STARVE_MAX_DEF = 3;
    localparam int LOCK_MAX_DEF   = 4;

    typedef enum logic {
        ST_FREE  = 1'b0,
        ST_DLOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

endpackage

// File: rtl/arb_resp_reg.sv
// Per-port read-return register: a one-cycle valid pulse plus data that
// only updates when a read was granted in the previous cycle.
module arb_resp_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= load;
            if (load) begin
                data <= din;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one asynchronous-read memory between instruction fetch and
// load/store: D-port priority, starvation limit for I, short D-port locks.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_ireq,
    input  logic [ADDR_W-1:0] w_iaddr,
    output logic              w_ignt,
    output logic [31:0]       r_irdata,
    output logic              r_irvalid,
    input  logic              w_dreq,
    input  logic              w_dwe,
    input  logic [ADDR_W-1:0] w_daddr,
    input  logic [31:0]       w_dwdata,
    input  logic              w_dlock,
    output logic              w_dgnt,
    output logic [31:0]       r_drdata,
    output logic              r_drvalid,
    output logic [ADDR_W-1:0] w_maddr,
    output logic              w_mwe,
    output logic [31:0]       w_mwdata,
    input  logic [31:0]       w_mrdata
);

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam int LCW = $clog2(LOCK_MAX + 1);

    arb_state_t     state_q, state_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic [LCW-1:0] lcnt_inc;
    logic           ifirst_q, ifirst_d;
    grant_t         grant;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q  <= ST_FREE;
            scnt_q   <= '0;
            lcnt_q   <= '0;
            ifirst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            lcnt_q   <= lcnt_d;
            ifirst_q <= ifirst_d;
        end
    end

    // ifirst marks the single FREE cycle after a forced lock release in which
    // a waiting fetch wins even if the starvation count has not saturated.
    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        lcnt_d   = lcnt_q;
        ifirst_d = 1'b0;
        grant    = GNT_NONE;
        lcnt_inc = lcnt_q + LCW'(1);

        if (w_rst_n) begin
            case (state_q)
                ST_FREE: begin
                    if (w_ireq && (!w_dreq || ifirst_q || scnt_q == SCW'(STARVE_MAX))) begin
                        grant = GNT_I;
                    end else if (w_dreq) begin
                        grant = GNT_D;
                    end
                    if (grant == GNT_D && w_dlock) begin
                        state_d = ST_DLOCK;
                        lcnt_d  = LCW'(1);
                    end
                end
                ST_DLOCK: begin
                    if (w_dreq) begin
                        grant = GNT_D;
                    end
                    if (!w_dlock || lcnt_inc >= LCW'(LOCK_MAX)) begin
                        state_d  = ST_FREE;
                        lcnt_d   = '0;
                        ifirst_d = w_dlock && w_ireq;
                    end else begin
                        lcnt_d = lcnt_inc;
                    end
                end
                default: state_d = ST_FREE;
            endcase

            if (grant == GNT_I || !w_ireq) begin
                scnt_d = '0;
            end else if (grant == GNT_D && scnt_q != SCW'(STARVE_MAX)) begin
                scnt_d = scnt_q + SCW'(1);
            end
        end
    end

    assign w_ignt   = (grant == GNT_I);
    assign w_dgnt   = (grant == GNT_D);
    assign w_maddr  = w_ignt ? w_iaddr : w_daddr;
    assign w_mwe    = w_dgnt & w_dwe;
    assign w_mwdata = w_dwdata;

    arb_resp_reg #(.DATA_W(32)) u_iresp (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .load  (w_ignt),
        .din   (w_mrdata),
        .valid (r_irvalid),
        .data  (r_irdata)
    );

    arb_resp_reg #(.DATA_W(32)) u_dresp (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .load  (w_dgnt & ~w_dwe),
        .din   (w_mrdata),
        .valid (r_drvalid),
        .data  (r_drdata)
    );

    assert property (@(posedge w_clk) disable iff (!w_rst_n) !(w_ignt && w_dgnt));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a cycle-level arbitration model and a shadow memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW   = MEM_ADDR_W;
    localparam int SMAX = 3;
    localparam int LMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ireq, dreq, dwe, dlock;
    logic [AW-1:0] iaddr, daddr, maddr;
    logic [31:0]   dwdata, irdata, drdata, mwdata, mrdata;
    logic          ignt, dgnt, irvalid, drvalid, mwe;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          mem_load = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic [31:0]   ref_mem [0:15];

    int checks = 0;
    int failures = 0;

    bit m_locked;
    int m_lock_len;
    int m_dstreak;
    bit m_owed;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX)) dut (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_ireq(ireq), .w_iaddr(iaddr), .w_ignt(ignt),
        .r_irdata(irdata), .r_irvalid(irvalid),
        .w_dreq(dreq), .w_dwe(dwe), .w_daddr(daddr), .w_dwdata(dwdata),
        .w_dlock(dlock), .w_dgnt(dgnt),
        .r_drdata(drdata), .r_drvalid(drvalid),
        .w_maddr(maddr), .w_mwe(mwe), .w_mwdata(mwdata), .w_mrdata(mrdata)
    );

    // Asynchronous-read, posedge-write memory standing in for m_amemory.
    always @(posedge clk) begin
        if (mem_load) mem[load_addr] <= load_data;
        else if (mwe) mem[maddr] <= mwdata;
    end
    assign mrdata = mem[maddr];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive(input logic i_r, input logic [AW-1:0] i_a, input logic d_r,
                         input logic d_we, input logic [AW-1:0] d_a, input logic [31:0] d_wd,
                         input logic d_lk);
        ireq = i_r; iaddr = i_a; dreq = d_r; dwe = d_we;
        daddr = d_a; dwdata = d_wd; dlock = d_lk;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_lock_len = 0; m_dstreak = 0; m_owed = 1'b0;
    endtask

    // Who should win this cycle, from the arbitration rules alone.
    task automatic model_grant(input bit i_r, input bit d_r, output bit gi, output bit gd);
        gi = 1'b0; gd = 1'b0;
        if (m_locked) gd = d_r;
        else if (i_r && (!d_r || m_owed || m_dstreak >= SMAX)) gi = 1'b1;
        else gd = d_r;
    endtask

    task automatic model_advance(input bit i_r, input bit d_lk, input bit gi, input bit gd);
        if (gi || !i_r) m_dstreak = 0;
        else if (gd) m_dstreak = (m_dstreak < SMAX) ? m_dstreak + 1 : SMAX;
        m_owed = 1'b0;
        if (m_locked) begin
            m_lock_len++;
            if (!d_lk) m_locked = 1'b0;
            else if (m_lock_len >= LMAX) begin
                m_locked = 1'b0;
                m_owed = i_r;
            end
        end else if (gd && d_lk) begin
            m_locked = 1'b1;
            m_lock_len = 1;
        end
    endtask

    // Holds reset while preloading the low 16 words from the shadow copy.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0, '0, '0, 0);
        for (int a = 0; a < 16; a++) begin
            mem_load = 1'b1; load_addr = AW'(a); load_data = ref_mem[a];
            next_cycle();
        end
        mem_load = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, AW'(2), 1, 1, AW'(4), 32'h5555_AAAA, 1);
        @(negedge clk);
        checks++; if (ignt !== 1'b0) begin failures++; $display("[TB] FAIL reset_ignt got=%b exp=0", ignt); end
        checks++; if (dgnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_dgnt got=%b exp=0", dgnt); end
        checks++; if (mwe !== 1'b0) begin failures++; $display("[TB] FAIL reset_mwe got=%b exp=0", mwe); end
        next_cycle();
        do_reset();
        @(negedge clk);
        checks++; if (irvalid !== 1'b0 || drvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valids got=%b%b exp=00", irvalid, drvalid); end
        checks++; if (irdata !== 32'h0 || drdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h/%h exp=0/0", irdata, drdata); end
        next_cycle();
    endtask

    task automatic test_i_fetch();
        do_reset();
        drive(1, AW'(5), 0, 0, '0, '0, 0);
        @(negedge clk);
        checks++; if (ignt !== 1'b1 || dgnt !== 1'b0) begin failures++; $display("[TB] FAIL ifetch_grant got=%b%b exp=10", ignt, dgnt); end
        checks++; if (maddr !== AW'(5)) begin failures++; $display("[TB] FAIL ifetch_maddr got=%0d exp=5", maddr); end
        next_cycle();
        drive(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checks++; if (irvalid !== 1'b1 || drvalid !== 1'b0) begin failures++; $display("[TB] FAIL ifetch_valid got=%b%b exp=10", irvalid, drvalid); end
        checks++; if (irdata !== 32'h2010_0001) begin failures++; $display("[TB] FAIL ifetch_data got=%h exp=20100001", irdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (irvalid !== 1'b0) begin failures++; $display("[TB] FAIL ifetch_pulse got=%b exp=0", irvalid); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic exp_d [5];
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        drive(1, AW'(3), 1, 0, AW'(8), '0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (dgnt !== exp_d[c] || ignt !== !exp_d[c]) begin
                failures++; $display("[TB] FAIL contention_c%0d got i=%b d=%b exp d=%b", c, ignt, dgnt, exp_d[c]);
            end
            if (c > 0) begin
                checks++;
                if (drvalid !== exp_d[c-1]) begin failures++; $display("[TB] FAIL contention_drvalid_c%0d got=%b exp=%b", c, drvalid, exp_d[c-1]); end
                if (exp_d[c-1]) begin
                    checks++;
                    if (drdata !== ref_mem[8]) begin failures++; $display("[TB] FAIL contention_drdata got=%h exp=%h", drdata, ref_mem[8]); end
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_store_fetch();
        do_reset();
        drive(1, AW'(10), 1, 1, AW'(10), 32'hDEAD_BEEF, 0);
        @(negedge clk);
        checks++; if (dgnt !== 1'b1 || ignt !== 1'b0) begin failures++; $display("[TB] FAIL stfetch_grant got=%b%b exp=01", ignt, dgnt); end
        checks++; if (mwe !== 1'b1 || maddr !== AW'(10) || mwdata !== 32'hDEAD_BEEF) begin
            failures++; $display("[TB] FAIL stfetch_write got we=%b a=%0d d=%h exp 1/10/deadbeef", mwe, maddr, mwdata); end
        next_cycle();
        ref_mem[10] = 32'hDEAD_BEEF;
        drive(1, AW'(10), 0, 0, '0, '0, 0);
        @(negedge clk);
        checks++; if (ignt !== 1'b1 || maddr !== AW'(10)) begin failures++; $display("[TB] FAIL stfetch_ignt got=%b a=%0d exp=1 a=10", ignt, maddr); end
        checks++; if (drvalid !== 1'b0) begin failures++; $display("[TB] FAIL stfetch_store_no_valid got=%b exp=0", drvalid); end
        next_cycle();
        drive(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checks++; if (irvalid !== 1'b1 || irdata !== 32'hDEAD_BEEF) begin
            failures++; $display("[TB] FAIL stfetch_rdata got v=%b d=%h exp 1/deadbeef", irvalid, irdata); end
        next_cycle();
    endtask

    task automatic test_lock_burst();
        logic exp_d [6];
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        drive(1, AW'(3), 1, 0, AW'(8), '0, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (dgnt !== exp_d[c] || ignt !== !exp_d[c]) begin
                failures++; $display("[TB] FAIL lock_burst_c%0d got i=%b d=%b exp d=%b", c, ignt, dgnt, exp_d[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_lock_early();
        logic exp_d [6];
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, AW'(3), 1, 0, AW'(8), '0, (c < 2) ? 1'b1 : 1'b0);
            @(negedge clk);
            checks++;
            if (dgnt !== exp_d[c] || ignt !== !exp_d[c]) begin
                failures++; $display("[TB] FAIL lock_early_c%0d got i=%b d=%b exp d=%b", c, ignt, dgnt, exp_d[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        drive(0, '0, 1, 0, AW'(8), '0, 1);
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        drive(1, AW'(5), 1, 1, AW'(8), 32'h1234_5678, 1);
        @(negedge clk);
        checks++; if (ignt !== 1'b0 || dgnt !== 1'b0 || mwe !== 1'b0) begin
            failures++; $display("[TB] FAIL midlock_reset_outputs got i=%b d=%b we=%b exp 000", ignt, dgnt, mwe); end
        next_cycle();
        rst_n = 1'b1;
        drive(1, AW'(5), 0, 0, '0, '0, 0);
        @(negedge clk);
        checks++; if (ignt !== 1'b1) begin failures++; $display("[TB] FAIL midlock_ifetch got=%b exp=1", ignt); end
        checks++; if (irvalid !== 1'b0 || drvalid !== 1'b0) begin failures++; $display("[TB] FAIL midlock_valids got=%b%b exp=00", irvalid, drvalid); end
        next_cycle();
        drive(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checks++; if (irvalid !== 1'b1 || irdata !== ref_mem[5]) begin
            failures++; $display("[TB] FAIL midlock_rdata got v=%b d=%h exp 1/%h", irvalid, irdata, ref_mem[5]); end
        next_cycle();
    endtask

    task automatic test_random();
        bit gi, gd, r_i, r_d, r_we, r_lk;
        logic [AW-1:0] r_ia, r_da;
        logic [31:0] r_wd;
        bit exp_iv, exp_dv;
        logic [31:0] exp_id, exp_dd;
        exp_iv = 1'b0; exp_dv = 1'b0; exp_id = '0; exp_dd = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r_i  = ($urandom_range(0, 99) < 60);
            r_d  = ($urandom_range(0, 99) < 70);
            r_we = ($urandom_range(0, 99) < 40);
            r_lk = ($urandom_range(0, 99) < 45);
            r_ia = AW'($urandom_range(0, 15));
            r_da = AW'($urandom_range(0, 15));
            r_wd = $urandom;
            drive(r_i, r_ia, r_d, r_we, r_da, r_wd, r_lk);
            model_grant(r_i, r_d, gi, gd);
            @(negedge clk);
            checks++;
            if (ignt !== gi || dgnt !== gd) begin
                failures++; $display("[TB] FAIL rand_grant_c%0d got i=%b d=%b exp i=%b d=%b", c, ignt, dgnt, gi, gd);
            end
            checks++;
            if (mwe !== (gd && r_we) || maddr !== (gi ? r_ia : r_da)) begin
                failures++; $display("[TB] FAIL rand_mem_c%0d got we=%b a=%0d exp we=%b a=%0d", c, mwe, maddr, gd && r_we, gi ? r_ia : r_da);
            end
            checks++;
            if (irvalid !== exp_iv || drvalid !== exp_dv) begin
                failures++; $display("[TB] FAIL rand_valid_c%0d got %b%b exp %b%b", c, irvalid, drvalid, exp_iv, exp_dv);
            end
            if (exp_iv) begin
                checks++;
                if (irdata !== exp_id) begin failures++; $display("[TB] FAIL rand_irdata_c%0d got=%h exp=%h", c, irdata, exp_id); end
            end
            if (exp_dv) begin
                checks++;
                if (drdata !== exp_dd) begin failures++; $display("[TB] FAIL rand_drdata_c%0d got=%h exp=%h", c, drdata, exp_dd); end
            end
            exp_iv = gi;
            if (gi) exp_id = ref_mem[r_ia[3:0]];
            exp_dv = gd && !r_we;
            if (exp_dv) exp_dd = ref_mem[r_da[3:0]];
            if (gd && r_we) ref_mem[r_da[3:0]] = r_wd;
            model_advance(r_i, r_lk, gi, gd);
            next_cycle();
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) ref_mem[a] = $urandom;
        ref_mem[5] = 32'h2010_0001;
        model_reset();
        drive(0, '0, 0, 0, '0, '0, 0);
        test_reset();
        test_i_fetch();
        test_contention();
        test_store_fetch();
        test_lock_burst();
        test_lock_early();
        test_reset_mid_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between instruction fetch (I-port) and load/store (D-port).
- Lets a multicycle processor share one m_amemory instance: asynchronous read, write at posedge.
- One memory access per cycle. D-port has priority, bounded by a starvation limit; D-port may lock the memory for short bursts.
- Read data is registered and returned one cycle after grant.

Parameters:
- ADDR_W, 11, word-address width driven to memory
- STARVE_MAX, 3, max consecutive D-grants while I-port waits before I-port is forced to win
- LOCK_MAX, 4, max consecutive cycles D-port may hold the lock

Ports:
- w_clk  in  1  clock; all state updates on posedge
- w_rst_n  in  1  reset, synchronous, active-low
- w_ireq  in  1  I-port read request; held until w_ignt
- w_iaddr  in  ADDR_W  I-port word address
- w_ignt  out  1  I-port granted this cycle (combinational)
- r_irdata  out  32  I-port read data, registered
- r_irvalid  out  1  r_irdata valid (1-cycle pulse)
- w_dreq  in  1  D-port request; held until w_dgnt
- w_dwe  in  1  D-port write enable (1 = store, 0 = load)
- w_daddr  in  ADDR_W  D-port word address
- w_dwdata  in  32  D-port store data
- w_dlock  in  1  D-port requests to keep the memory after this grant
- w_dgnt  out  1  D-port granted this cycle (combinational)
- r_drdata  out  32  D-port load data, registered
- r_drvalid  out  1  r_drdata valid (1-cycle pulse; loads only)
- w_maddr  out  ADDR_W  memory address
- w_mwe  out  1  memory write enable
- w_mwdata  out  32  memory write data
- w_mrdata  in  32  memory asynchronous read data

Behaviour:
- Reset (w_rst_n==0 at posedge):
  - state=FREE, r_scnt=0, r_lcnt=0
  - r_irvalid=0, r_drvalid=0, r_irdata=0, r_drdata=0
  - While w_rst_n==0, w_ignt=w_dgnt=w_mwe=0 combinationally.
- States: FREE, DLOCK.
- FREE grant rule, evaluated each cycle:
  - Only ireq: I wins.
  - Only dreq: D wins.
  - Both, r_scnt<STARVE_MAX: D wins.
  - Both, r_scnt==STARVE_MAX: I wins.
- DLOCK grant rule:
  - D only; w_ignt=0 regardless of w_ireq.
  - If dreq is low in DLOCK, no grant; the cycle is idle.
- Starvation counter r_scnt:
  - +1 on each D-grant with w_ireq high; saturates at STARVE_MAX.
  - Cleared on any I-grant, or any cycle with w_ireq low.
- Transitions:
  - FREE->DLOCK when D is granted with w_dlock=1; r_lcnt<=1.
  - DLOCK stays while w_dlock=1 and r_lcnt<LOCK_MAX; r_lcnt+1 per cycle, granted or idle.
  - DLOCK->FREE when w_dlock=0, or r_lcnt==LOCK_MAX (forced release); r_lcnt<=0.
  - Forced release plus pending ireq: the next FREE cycle grants I regardless of r_scnt.
- Memory mux:
  - w_maddr = granted port's address (D-port address when nothing is granted).
  - w_mwe = w_dgnt & w_dwe.
  - w_mwdata = w_dwdata.
- Read return:
  - On posedge: r_irvalid<=w_ignt; r_drvalid<=w_dgnt&~w_dwe.
  - rdata registers load w_mrdata only when the matching valid is set, else hold.
  - Latency: grant cycle N -> data valid in cycle N+1.
- Simultaneous D-store and I-fetch to the same address:
  - D wins (unless the starvation limit is reached); the I-read in a later cycle sees the new data.
  - If I wins, it reads the old value.
- Exactly one grant per cycle at most; w_ignt&w_dgnt is never 1 (assertion).
- Requests dropped before grant are not errors; no state is kept for them.
- Reset mid-lock: returns to FREE; any return data pending for next cycle is discarded (valid=0).

Decomposition:
- Shared package holds:
  - state encoding (ST_FREE=1'b0, ST_DLOCK=1'b1)
  - default STARVE_MAX/LOCK_MAX constants
  - the word-address width constant (11) also used by m_amemory
- One natural sub-module, arb_resp_reg: per-port valid/data return register (instantiated twice).
- Grant logic, counters and FSM stay in the top.

Test Plan:
- I-only fetch: ireq=1, iaddr=5, mem[5]=0x2010_0001 -> ignt=1 same cycle; next cycle r_irvalid=1, r_irdata=0x2010_0001; r_drvalid=0.
- Contention: ireq=dreq=1 held, loads to addr 8 -> dgnt for 3 cycles, ignt on the 4th, then dgnt resumes; r_scnt cycles 0,1,2,3,0.
- Store then fetch same address: D store 0xDEADBEEF to addr 10 with ireq to 10 -> mwe=1, dgnt=1 in cycle N; ignt in N+1; r_irdata=0xDEADBEEF in N+2.
- Lock burst: dlock=1 held for 6 cycles, ireq=1 -> 4 consecutive dgnt (LOCK_MAX), forced release, next grant to I, then D.
- Lock early release: dlock high 2 cycles then low -> state FREE after the 3rd D-grant; ireq served on the next contention per the starvation rule.
- Reset mid-DLOCK: w_rst_n=0 for one posedge during lock -> ignt=dgnt=mwe=0 while low; after release, state FREE, valids 0, I-only request granted immediately.
